// File: rtl/interrupt_controller_if.sv
// Bus bundle between the interrupt controller and its two partners:
//   - software configuration write port (cfg_we, cfg_addr, cfg_wdata);
//   - hazard control unit handshake (interrupt, interrupt_vector_address,
//     int_ack, int_return).
// master: the side driving configuration writes and ack/return pulses.
// slave : the interrupt controller itself.
interface interrupt_controller_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        int_ack;
  logic        int_return;
  logic        interrupt;
  logic [13:0] interrupt_vector_address;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, int_ack, int_return,
    input  interrupt, interrupt_vector_address
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, int_ack, int_return,
    output interrupt, interrupt_vector_address
  );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller feeding the pipeline hazard unit.
// Synchronises and edge-detects raw interrupt lines, latches them as pending,
// gates them with per-source masks and a global enable, raises one request at
// a time (lowest index wins) and tracks the in-service source until return.
//
// Ports:
//   clock, reset_n   : system clock, async active-low reset
//   irq_src          : raw rising-edge interrupt lines (asynchronous)
//   bus (slave)      : config write port + hazard unit handshake
//   pending          : pending latch
//   mask_en          : per-source mask enable register
//   in_service       : one-hot in-service source, or 0
//   ctrl_state       : 0 = IDLE, 1 = REQUEST, 2 = IN_SERVICE
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | no request outstanding; raise one as soon as a source is eligible
// REQUEST     | interrupt held high with stable vector until int_ack
// IN_SERVICE  | handler running; no nesting, wait for int_return
module interrupt_controller #(
  parameter int          NUM_SOURCES   = 8,
  parameter logic [13:0] VECTOR_BASE   = 14'h0100,
  parameter int          VECTOR_STRIDE = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_SOURCES-1:0] irq_src,
  interrupt_controller_if.slave  bus,
  output logic [NUM_SOURCES-1:0] pending,
  output logic [NUM_SOURCES-1:0] mask_en,
  output logic [NUM_SOURCES-1:0] in_service,
  output logic [1:0]             ctrl_state
);

  localparam int ID_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REQUEST    = 2'd1,
    ST_IN_SERVICE = 2'd2
  } state_t;

  state_t                 state_q, state_n;
  logic [NUM_SOURCES-1:0] sync1_q, sync2_q, dly_q;
  logic [NUM_SOURCES-1:0] pending_q, mask_q, in_service_q;
  logic                   gen_q;
  logic [ID_W-1:0]        id_q;
  logic                   int_q;
  logic [13:0]            vec_q;

  logic [NUM_SOURCES-1:0] edge_det, wdata, eligible;
  logic [NUM_SOURCES-1:0] set_vec, clr_vec;
  logic [ID_W-1:0]        win_id;
  logic                   any_elig;
  logic                   take_req, take_ack;
  logic                   wr_mask, wr_set, wr_clr, wr_gen;
  logic                   unused_ok;

  // Wraps modulo 2^14 by truncation.
  function automatic logic [13:0] vec_of(input logic [ID_W-1:0] id);
    int v;
    v = int'(VECTOR_BASE) + int'(id) * VECTOR_STRIDE;
    return v[13:0];
  endfunction

  // Upper write-data bits beyond the source count carry no meaning.
  assign unused_ok = ^bus.cfg_wdata;

  assign wdata    = bus.cfg_wdata[NUM_SOURCES-1:0];
  assign wr_mask  = bus.cfg_we && (bus.cfg_addr == 2'd0);
  assign wr_set   = bus.cfg_we && (bus.cfg_addr == 2'd1);
  assign wr_clr   = bus.cfg_we && (bus.cfg_addr == 2'd2);
  assign wr_gen   = bus.cfg_we && (bus.cfg_addr == 2'd3);

  assign edge_det = sync2_q & ~dly_q;
  assign eligible = gen_q ? (pending_q & mask_q) : '0;
  assign any_elig = |eligible;

  always_comb begin
    win_id = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    take_req = 1'b0;
    take_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          state_n  = ST_REQUEST;
          take_req = 1'b1;
        end
      end
      ST_REQUEST: begin
        // Ack wins over a simultaneous return; masking never withdraws.
        if (bus.int_ack) begin
          state_n  = ST_IN_SERVICE;
          take_ack = 1'b1;
        end
      end
      ST_IN_SERVICE: begin
        if (bus.int_return) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Sets (edge or software) take priority over clears on the same bit.
  assign set_vec = edge_det | (wr_set ? wdata : '0);
  assign clr_vec = (wr_clr ? wdata : '0) |
                   (take_ack ? (NUM_SOURCES'(1) << id_q) : '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      dly_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      gen_q        <= 1'b0;
      in_service_q <= '0;
      id_q         <= '0;
      int_q        <= 1'b0;
      vec_q        <= '0;
    end else begin
      sync1_q   <= irq_src;
      sync2_q   <= sync1_q;
      dly_q     <= sync2_q;
      pending_q <= (pending_q & ~clr_vec) | set_vec;
      if (wr_mask) mask_q <= wdata;
      if (wr_gen)  gen_q  <= bus.cfg_wdata[0];

      if (take_req) begin
        int_q <= 1'b1;
        vec_q <= vec_of(win_id);
        id_q  <= win_id;
      end else if (take_ack) begin
        int_q        <= 1'b0;
        in_service_q <= NUM_SOURCES'(1) << id_q;
      end else if (state_q == ST_IN_SERVICE && bus.int_return) begin
        in_service_q <= '0;
      end
    end
  end

  assign bus.interrupt                = int_q;
  assign bus.interrupt_vector_address = vec_q;
  assign pending                      = pending_q;
  assign mask_en                      = mask_q;
  assign in_service                   = in_service_q;
  assign ctrl_state                   = state_q;

endmodule
